cache_sequencer: RTL and testbench
==================================

// Module: cache_sequencer
// PURPOSE
//  FSM sequencing the direct-mapped tag/valid unit and its data array between one CPU port and main memory.
//  Read hits are served from cache; read misses fetch from memory, then fill the line.
//  Writes are write-through and write-allocate (line = one word).
//  Also keeps saturating hit/miss statistics and aborts memory accesses that never get an acknowledge.
// PARAMETERS
//  ADDR_WIDTH  32  CPU/memory byte-free word address width; also the tag-unit address width
//  DATA_WIDTH  32  data word width
//  CNT_WIDTH   16  width of each statistics counter
//  TIMEOUT     64  max cycles waiting for mem_ack before abort (>=2)
// PORTS
//  clk          in   1           clock, all state on rising edge
//  reset        in   1           reset, asynchronous, active-high
//  cpu_req      in   1           CPU request; held high until cpu_ready
//  cpu_we       in   1           1 = write, 0 = read; sampled with cpu_req
//  cpu_addr     in   ADDR_WIDTH  request address; sampled with cpu_req
//  cpu_wdata    in   DATA_WIDTH  write data; sampled with cpu_req
//  cpu_rdata    out  DATA_WIDTH  read data; valid while cpu_ready=1 and cpu_err=0
//  cpu_ready    out  1           one-cycle completion pulse
//  cpu_err      out  1           with cpu_ready: memory timeout, data invalid
//  cache_addr   out  ADDR_WIDTH  address to tag unit and data array (latched request addr)
//  cache_hit    in   1           combinational hit from tag unit for cache_addr
//  cache_rdata  in   DATA_WIDTH  data-array word at cache_addr (combinational)
//  cache_wr_en  out  1           write tag+valid+data for cache_addr; tag unit captures before next rising edge
//  cache_wdata  out  DATA_WIDTH  fill/write data for data array
//  mem_req      out  1           memory request, held until mem_ack or timeout
//  mem_we       out  1           memory write strobe qualifier
//  mem_addr     out  ADDR_WIDTH  memory address (= latched request addr)
//  mem_wdata    out  DATA_WIDTH  memory write data
//  mem_rdata    in   DATA_WIDTH  memory read data, valid with mem_ack
//  mem_ack      in   1           one-cycle memory completion
//  stat_clr     in   1           synchronous clear of both counters
//  hit_count    out  CNT_WIDTH   lookups that hit (reads and writes)
//  miss_count   out  CNT_WIDTH   lookups that missed
// BEHAVIOUR
//  Reset:
//   - State = IDLE; all outputs and counters 0.
//   - Latched addr/data cleared; timeout counter cleared.
//   - Reset mid-access drops mem_req immediately; no fill and no cpu_ready are issued.
//  States: IDLE, LOOKUP, MEM_RD, MEM_WR, FILL, RESP.
//  IDLE:
//   - cpu_req=1 at an edge latches cpu_we/cpu_addr/cpu_wdata, then goes to LOOKUP.
//   - cpu_req=0 stays in IDLE.
//  LOOKUP:
//   - One cycle; cache_hit is evaluated here.
//   - Read hit: latch cache_rdata, go to RESP.
//   - Read miss: go to MEM_RD.
//   - Any write: go to MEM_WR.
//   - hit_count or miss_count increments by one per lookup.
//  MEM_RD / MEM_WR:
//   - mem_req=1; mem_we=1 only in MEM_WR.
//   - mem_ack latches mem_rdata (read) or the write data (write) as fill data, then goes to FILL.
//   - mem_ack in the same cycle mem_req first rises is legal.
//   - TIMEOUT cycles without ack: set the error flag, go to RESP, skip FILL.
//  FILL:
//   - cache_wr_en=1 for exactly one cycle with cache_wdata = fill data.
//   - Then go to RESP.
//  RESP:
//   - cpu_ready=1 for one cycle; cpu_err = error flag; cpu_rdata = latched data.
//   - Then go to IDLE and clear the error flag.
//  Latency:
//   - Read hit: cpu_ready 2 cycles after the accepting edge.
//   - Miss or write: 4 + memory wait cycles.
//  CPU handshake:
//   - The CPU must drop cpu_req in the cycle after cpu_ready.
//   - cpu_req still high in IDLE after RESP is a new request.
//   - cpu_req and the cpu_* inputs are ignored outside IDLE.
//  Counters:
//   - Saturate at all-ones; no wrap.
//   - stat_clr wins over a simultaneous increment.
//  mem_ack outside MEM_RD/MEM_WR is ignored. cache_wr_en is never asserted on a timeout.
// TESTING
//  1. Read 0x10 on an empty cache; mem_rdata=0xAAAA5555, ack after 3 cycles.
//     -> mem_req for 3 cycles, one FILL pulse, cpu_rdata=0xAAAA5555, miss_count=1.
//  2. Repeat read 0x10.
//     -> no mem_req; cpu_ready 2 cycles after acceptance; data 0xAAAA5555; hit_count=1.
//  3. Write 0x18 data 0x12345678 with immediate ack; then read 0x18.
//     -> mem_we=1 and FILL on the write; the read hits and returns 0x12345678.
//  4. Read 0x20 with mem_ack never asserted, TIMEOUT=64.
//     -> mem_req drops after 64 cycles; cpu_ready=1 and cpu_err=1; no cache_wr_en.
//  5. Assert reset during MEM_RD.
//     -> mem_req=0 asynchronously; state IDLE; counters 0; no cpu_ready after release.
//  6. CNT_WIDTH=2: 5 hits, then stat_clr coincident with a hit.
//     -> hit_count saturates at 3, then reads 0 after the clear.

Source files
------------

// File: rtl/cache_sequencer.sv
// Sequencer between one CPU port, a direct-mapped tag/data array and main memory.
// Write-through / write-allocate, one-word lines, saturating hit/miss counters, memory timeout abort.
module cache_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_ready_o,
  output logic                  cpu_err_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  output logic                  cache_wr_en_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  input  logic                  stat_clr_i,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_FILL   = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    err_q;
  logic [TW-1:0]           tmo_q;
  logic [CNT_WIDTH-1:0]    hit_q, miss_q;
  logic                    mem_state_s;
  logic                    timeout_s;

  assign mem_state_s = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout_s   = (tmo_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) state_d = S_LOOKUP;
        else           state_d = S_IDLE;
      end
      S_LOOKUP: begin
        if (we_q)             state_d = S_MEM_WR;
        else if (cache_hit_i) state_d = S_RESP;
        else                  state_d = S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ack_i)      state_d = S_FILL;
        else if (timeout_s) state_d = S_RESP;
        else                state_d = state_q;
      end
      S_FILL:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    cpu_ready_o   = 1'b0;
    cpu_err_o     = 1'b0;
    cache_wr_en_o = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    case (state_q)
      S_MEM_RD: mem_req_o = 1'b1;
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      S_FILL:   cache_wr_en_o = 1'b1;
      S_RESP: begin
        cpu_ready_o = 1'b1;
        cpu_err_o   = err_q;
      end
      default: cpu_ready_o = 1'b0;
    endcase
  end

  assign cpu_rdata_o   = data_q;
  assign cache_wdata_o = data_q;
  assign cache_addr_o  = addr_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign hit_count_o   = hit_q;
  assign miss_count_o  = miss_q;

  // Request latch, response/fill data, error flag and memory wait timer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
      tmo_q   <= {TW{1'b0}};
    end else begin
      if ((state_q == S_IDLE) && cpu_req_i) begin
        we_q    <= cpu_we_i;
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_wdata_i;
      end
      case (state_q)
        S_LOOKUP: if (!we_q && cache_hit_i) data_q <= cache_rdata_i;
        S_MEM_RD: if (mem_ack_i) data_q <= mem_rdata_i;
        S_MEM_WR: if (mem_ack_i) data_q <= wdata_q;
        default:  data_q <= data_q;
      endcase
      if (mem_state_s && !mem_ack_i && timeout_s) err_q <= 1'b1;
      else if (state_q == S_RESP)                err_q <= 1'b0;
      // Timer runs only while waiting; it is back at zero on every entry to a memory state
      if (mem_state_s && !mem_ack_i && !timeout_s) tmo_q <= tmo_q + TW'(1);
      else                                         tmo_q <= {TW{1'b0}};
    end
  end

  // Saturating lookup statistics; a clear beats a coincident increment
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_q  <= {CNT_WIDTH{1'b0}};
      miss_q <= {CNT_WIDTH{1'b0}};
    end else if (stat_clr_i) begin
      hit_q  <= {CNT_WIDTH{1'b0}};
      miss_q <= {CNT_WIDTH{1'b0}};
    end else if (state_q == S_LOOKUP) begin
      if (cache_hit_i) begin
        if (hit_q != CNT_MAX) hit_q <= hit_q + CNT_WIDTH'(1);
      end else begin
        if (miss_q != CNT_MAX) miss_q <= miss_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_sequencer.sv
// Randomized scoreboard bench for cache_sequencer: the bench supplies an 8-line tag/data
// array and a memory responder; a reference cache model predicts every CPU response.
module tb_cache_sequencer;
  localparam int CW = 2;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [31:0] cache_addr, cache_rdata, cache_wdata;
  logic        cache_hit, cache_wr_en;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stat_clr;
  logic [CW-1:0] hit_count, miss_count;

  cache_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .cpu_ready_o(cpu_ready), .cpu_err_o(cpu_err), .cache_addr_o(cache_addr),
    .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata), .cache_wr_en_o(cache_wr_en),
    .cache_wdata_o(cache_wdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack), .stat_clr_i(stat_clr), .hit_count_o(hit_count),
    .miss_count_o(miss_count));

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_data;
    logic [31:0] data;
    int          err, hitc, missc, lat, fills, mreqs, fill_base, mreq_base;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;
  int cyc, fill_tot, mreq_tot, accept_cyc, done_cnt;
  int plan_d;
  bit plan_to;

  function automatic logic [31:0] memdef(input int a);
    return 32'hC0DE_0000 ^ (a * 32'h0001_0F1D);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Tag/valid/data array seen by the DUT (8 direct-mapped lines)
  logic        tv[8];
  logic [28:0] tt[8];
  logic [31:0] td[8];
  assign cache_hit   = tv[cache_addr[2:0]] && (tt[cache_addr[2:0]] == cache_addr[31:3]);
  assign cache_rdata = td[cache_addr[2:0]];
  initial begin
    for (int i = 0; i < 8; i++) begin tv[i] = 1'b0; tt[i] = '0; td[i] = '0; end
    forever begin
      @(posedge clk);
      if (cache_wr_en) begin
        tv[cache_addr[2:0]] <= 1'b1;
        tt[cache_addr[2:0]] <= cache_addr[31:3];
        td[cache_addr[2:0]] <= cache_wdata;
      end
    end
  end

  // Cycle and activity counters sampled on rising edges
  initial begin
    cyc = 0; fill_tot = 0; mreq_tot = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cache_wr_en) fill_tot++;
      if (mem_req) mreq_tot++;
    end
  end

  // Memory responder, with stray acks while no request is pending
  logic [31:0] mem[64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = memdef(i);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !reset) begin
        if (!plan_to) begin
          repeat (plan_d) @(negedge clk);
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[5:0]];
          if (mem_we) mem[mem_addr[5:0]] = mem_wdata;
        end else begin
          while (mem_req) @(negedge clk);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every completion is matched against the oldest prediction
  initial begin
    exp_t e;
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (cpu_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ready: got cpu_ready=1, expected no completion");
        end else begin
          e = sb.pop_front();
          check("cpu_err", cpu_err, e.err);
          if (e.chk_data) check("cpu_rdata", cpu_rdata, e.data);
          check("hit_count", hit_count, e.hitc);
          check("miss_count", miss_count, e.missc);
          check("latency", cyc - accept_cyc + 1, e.lat);
          check("fill_pulses", fill_tot - e.fill_base, e.fills);
          check("mem_req_cycles", mreq_tot - e.mreq_base, e.mreqs);
        end
        done_cnt++;
      end
    end
  end

  // Reference cache and memory
  bit          rv[8];
  int          rt[8];
  logic [31:0] rd[8];
  logic [31:0] ref_mem[64];
  int          rhit, rmiss;
  bit          aborted = 1'b0;
  int          cmax = (1 << CW) - 1;

  task automatic do_txn(input bit we, input int addr, input logic [31:0] wd,
                        input int d, input bit to, input int clr);
    int   i = addr % 8;
    bit   h;
    int   start;
    exp_t e;
    if (aborted) return;
    if (clr == 1) begin
      stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
      rhit = 0; rmiss = 0;
    end
    h = rv[i] && (rt[i] == addr / 8);
    if (h) rhit = (rhit < cmax) ? rhit + 1 : cmax;
    else   rmiss = (rmiss < cmax) ? rmiss + 1 : cmax;
    if (clr == 2) begin rhit = 0; rmiss = 0; end
    e.data = 32'h0;
    if (!we && h) begin
      e.err = 0; e.data = rd[i]; e.lat = 2; e.fills = 0; e.mreqs = 0;
    end else if (to) begin
      e.err = 1; e.lat = TO + 2; e.fills = 0; e.mreqs = TO;
    end else begin
      e.err = 0; e.lat = d + 4; e.fills = 1; e.mreqs = d + 1;
      if (we) begin ref_mem[addr] = wd; e.data = wd; end
      else e.data = ref_mem[addr];
      rv[i] = 1'b1; rt[i] = addr / 8; rd[i] = e.data;
    end
    e.chk_data = !we && (e.err == 0);
    e.hitc = rhit; e.missc = rmiss;
    e.fill_base = fill_tot; e.mreq_base = mreq_tot;
    sb.push_back(e);
    plan_d = d; plan_to = to;
    start = done_cnt;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk); #1;
    accept_cyc = cyc;
    cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    if (clr == 2) begin
      @(negedge clk); stat_clr = 1'b1;
      @(negedge clk); stat_clr = 1'b0;
    end
    for (int k = 0; k < 200 && done_cnt == start; k++) @(negedge clk);
    if (done_cnt == start) begin
      n_cmp++; n_bad++; aborted = 1'b1;
      $display("FAIL completion_timeout: got no cpu_ready in 200 cycles, expected one");
    end
    cpu_req = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    int a, fb;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; stat_clr = 1'b0;
    plan_d = 0; plan_to = 1'b0; rhit = 0; rmiss = 0;
    for (int i = 0; i < 8; i++) begin rv[i] = 1'b0; rt[i] = 0; rd[i] = '0; end
    for (int i = 0; i < 64; i++) ref_mem[i] = memdef(i);
    reset = 1'b1;
    #1;
    mem[16] = 32'hAAAA_5555; ref_mem[16] = 32'hAAAA_5555;
    repeat (3) @(negedge clk);
    check("reset_cpu_ready", cpu_ready, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_cache_wr_en", cache_wr_en, 0);
    check("reset_hit_count", hit_count, 0);
    check("reset_miss_count", miss_count, 0);
    check("reset_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: miss then hit, write-allocate, timeout
    do_txn(1'b0, 16, 32'h0, 2, 1'b0, 0);
    do_txn(1'b0, 16, 32'h0, 0, 1'b0, 0);
    do_txn(1'b1, 24, 32'h1234_5678, 0, 1'b0, 0);
    do_txn(1'b0, 24, 32'h0, 0, 1'b0, 0);
    do_txn(1'b0, 32, 32'h0, 0, 1'b1, 0);
    // Saturation, then a clear coincident with a hit
    for (int k = 0; k < 5; k++) do_txn(1'b0, 24, 32'h0, 0, 1'b0, 0);
    do_txn(1'b0, 24, 32'h0, 0, 1'b0, 2);

    for (int k = 0; k < 150; k++) begin
      int cr = $urandom_range(0, 15);
      do_txn(1'($urandom_range(0, 3) == 0), $urandom_range(0, 63), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 19) == 0,
             (cr == 0) ? 1 : ((cr == 1) ? 2 : 0));
    end

    // Reset in the middle of a read miss
    if (!aborted) begin
      a = 0;
      while (rv[a % 8] && rt[a % 8] == a / 8) a++;
      plan_to = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      check("mem_req_before_reset", mem_req, 1);
      fb = fill_tot;
      #1 reset = 1'b1;
      #1;
      check("mem_req_async_reset", mem_req, 0);
      check("hit_after_reset", hit_count, 0);
      check("miss_after_reset", miss_count, 0);
      @(negedge clk); reset = 1'b0;
      rhit = 0; rmiss = 0;
      repeat (80) @(negedge clk);
      check("fill_after_reset", fill_tot - fb, 0);
      for (int k = 0; k < 10; k++)
        do_txn(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom,
               $urandom_range(0, 3), 1'b0, 0);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
